// File: rtl/alu_issue_unit_if.sv
// Bundle of the instruction, preload, ALU and status signals of alu_issue_unit.
//   slave  : the issue unit (consumes instructions/preloads/ALU results, drives ALU operands).
//   master : whoever feeds instructions and hosts the ALU (testbench or surrounding core).
// Signals:
//   inValid/inReady/inOp/inRd/inRs/inRt : instruction handshake
//   loadEn/loadAddr/loadData             : direct register preload
//   aluA/aluB/aluOp                      : operands and opcode to the ALU
//   aluResult/aluZero                    : registered result from the ALU
//   done/zeroFlag/illegalOp/retired      : status
//   dbgAddr/dbgData                      : combinational register-file debug read
interface alu_issue_unit_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 3,
  parameter int unsigned COUNT_W    = 16
);
  logic                  inValid;
  logic                  inReady;
  logic [2:0]            inOp;
  logic [REG_ADDR_W-1:0] inRd;
  logic [REG_ADDR_W-1:0] inRs;
  logic [REG_ADDR_W-1:0] inRt;
  logic                  loadEn;
  logic [REG_ADDR_W-1:0] loadAddr;
  logic [DATA_W-1:0]     loadData;
  logic [DATA_W-1:0]     aluA;
  logic [DATA_W-1:0]     aluB;
  logic [2:0]            aluOp;
  logic [DATA_W-1:0]     aluResult;
  logic                  aluZero;
  logic                  done;
  logic                  zeroFlag;
  logic                  illegalOp;
  logic [COUNT_W-1:0]    retired;
  logic [REG_ADDR_W-1:0] dbgAddr;
  logic [DATA_W-1:0]     dbgData;

  modport slave (
    input  inValid, inOp, inRd, inRs, inRt, loadEn, loadAddr, loadData,
           aluResult, aluZero, dbgAddr,
    output inReady, aluA, aluB, aluOp, done, zeroFlag, illegalOp, retired, dbgData
  );

  modport master (
    output inValid, inOp, inRd, inRs, inRt, loadEn, loadAddr, loadData,
           aluResult, aluZero, dbgAddr,
    input  inReady, aluA, aluB, aluOp, done, zeroFlag, illegalOp, retired, dbgData
  );
endinterface

// File: rtl/alu_issue_unit.sv
// Operand/issue stage in front of a registered ALU. Holds a small register file (r0 reads as 0),
// accepts one instruction per three cycles (IDLE -> ISSUE -> CAPTURE), drives the ALU operands
// during ISSUE and writes the ALU result back to rd at the end of CAPTURE.
// Ports:
//   clock : single clock, all state updates on posedge
//   clear : synchronous active-high reset, overrides every other input
//   bus   : alu_issue_unit_if.slave (instruction handshake, preload, ALU side, status, debug read)
module alu_issue_unit #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 3,
  parameter int unsigned COUNT_W    = 16
) (
  input  logic              clock,
  input  logic              clear,
  alu_issue_unit_if.slave   bus
);

  localparam int unsigned NumRegs = 2 ** REG_ADDR_W;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StCapture
  } state_e;

  state_e                r_state;
  state_e                w_state_next;
  logic                  w_in_ready;
  logic                  w_handshake;

  logic [DATA_W-1:0]     r_regs [NumRegs];
  logic [REG_ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0]     r_alu_a;
  logic [DATA_W-1:0]     r_alu_b;
  logic [2:0]            r_alu_op;
  logic                  r_done;
  logic                  r_zero_flag;
  logic                  r_illegal;
  logic [COUNT_W-1:0]    r_retired;

  // Next-state and handshake decode
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_handshake  = 1'b0;
    unique case (r_state)
      StIdle: begin
        // A preload takes the cycle; the instruction waits for the next one.
        w_in_ready  = ~bus.loadEn;
        w_handshake = bus.inValid & w_in_ready;
        if (w_handshake) begin
          w_state_next = StIssue;
        end
      end
      StIssue:   w_state_next = StCapture;
      StCapture: w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Register file, operand registers and status
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < NumRegs; i++) begin
        r_regs[i] <= '0;
      end
      r_rd        <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_done      <= 1'b0;
      r_zero_flag <= 1'b1;
      r_illegal   <= 1'b0;
      r_retired   <= '0;
    end else begin
      r_done <= (r_state == StCapture);
      if (r_state == StIdle) begin
        if (bus.loadEn && (bus.loadAddr != '0)) begin
          r_regs[bus.loadAddr] <= bus.loadData;
        end
        // Operands are read at the accepting edge so they are stable for all of ISSUE; the
        // previous writeback has already landed, so no forwarding is needed.
        if (w_handshake) begin
          r_rd     <= bus.inRd;
          r_alu_a  <= r_regs[bus.inRs];
          r_alu_b  <= r_regs[bus.inRt];
          r_alu_op <= bus.inOp;
          if (bus.inOp > 3'b100) begin
            r_illegal <= 1'b1;
          end
        end
      end
      if (r_state == StCapture) begin
        if (r_rd != '0) begin
          r_regs[r_rd] <= bus.aluResult;
        end
        r_zero_flag <= bus.aluZero;
        r_retired   <= r_retired + COUNT_W'(1);
      end
    end
  end

  assign bus.inReady   = w_in_ready;
  assign bus.aluA      = r_alu_a;
  assign bus.aluB      = r_alu_b;
  assign bus.aluOp     = r_alu_op;
  assign bus.done      = r_done;
  assign bus.zeroFlag  = r_zero_flag;
  assign bus.illegalOp = r_illegal;
  assign bus.retired   = r_retired;
  assign bus.dbgData   = (bus.dbgAddr == '0) ? '0 : r_regs[bus.dbgAddr];

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a behavioural registered ALU.
module tb_alu_issue_unit;

  logic clock = 1'b0;
  logic clear = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  alu_issue_unit_if #(.DATA_W(32), .REG_ADDR_W(3), .COUNT_W(16)) bus ();

  alu_issue_unit #(.DATA_W(32), .REG_ADDR_W(3), .COUNT_W(16)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  // Registered ALU: result appears the cycle after operands are presented.
  logic [31:0] alu_calc;
  always_comb begin
    alu_calc = '0;
    case (bus.aluOp)
      3'b000:  alu_calc = bus.aluA + bus.aluB;
      3'b001:  alu_calc = bus.aluA - bus.aluB;
      3'b010:  alu_calc = bus.aluA & bus.aluB;
      3'b011:  alu_calc = bus.aluA | bus.aluB;
      3'b100:  alu_calc = bus.aluA ^ bus.aluB;
      default: alu_calc = '0;
    endcase
  end
  always @(posedge clock) begin
    bus.aluResult <= alu_calc;
    bus.aluZero   <= (alu_calc == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] addr, input logic [31:0] exp);
    bus.dbgAddr = addr;
    #1;
    chk(tag, bus.dbgData, exp);
  endtask

  task automatic load(input logic [2:0] addr, input logic [31:0] data);
    bus.loadEn   = 1'b1;
    bus.loadAddr = addr;
    bus.loadData = data;
    tick();
    bus.loadEn = 1'b0;
  endtask

  // Present an instruction, wait (bounded) for acceptance, then run to the done cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [2:0] rd,
                        input logic [2:0] rs, input logic [2:0] rt);
    bit ok = 1'b0;
    bus.inValid = 1'b1;
    bus.inOp    = op;
    bus.inRd    = rd;
    bus.inRs    = rs;
    bus.inRt    = rt;
    #1;
    for (int n = 0; n < 10; n++) begin
      if (bus.inReady) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
    tick();
    bus.inValid = 1'b0;
    tick();
    tick();
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.inValid  = 1'b0;
    bus.inOp     = '0;
    bus.inRd     = '0;
    bus.inRs     = '0;
    bus.inRt     = '0;
    bus.loadEn   = 1'b0;
    bus.loadAddr = '0;
    bus.loadData = '0;
    bus.dbgAddr  = '0;

    tick();
    tick();
    clear = 1'b0;
    chk("rst_in_ready", {31'd0, bus.inReady}, 32'd1);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_zero_flag", {31'd0, bus.zeroFlag}, 32'd1);
    chk("rst_illegal", {31'd0, bus.illegalOp}, 32'd0);
    chk("rst_retired", {16'd0, bus.retired}, 32'd0);
    chk("rst_alu_a", bus.aluA, 32'd0);
    for (int a = 0; a < 8; a++) chk_reg("rst_reg", 3'(a), 32'd0);

    // Preloads, r0 write ignored
    tick();
    load(3'd1, 32'd5);
    load(3'd2, 32'd3);
    load(3'd4, 32'd77);
    load(3'd0, 32'd9);
    chk_reg("pre_r1", 3'd1, 32'd5);
    chk_reg("pre_r0", 3'd0, 32'd0);

    // add r3,r1,r2 stepped cycle by cycle; a load during ISSUE must be ignored
    tick();
    bus.inValid = 1'b1;
    bus.inOp = 3'b000; bus.inRd = 3'd3; bus.inRs = 3'd1; bus.inRt = 3'd2;
    #1;
    chk("add_ready", {31'd0, bus.inReady}, 32'd1);
    tick();
    bus.inValid  = 1'b0;
    bus.loadEn   = 1'b1;
    bus.loadAddr = 3'd7;
    bus.loadData = 32'hAA;
    #1;
    chk("add_issue_a", bus.aluA, 32'd5);
    chk("add_issue_b", bus.aluB, 32'd3);
    chk("add_issue_op", {29'd0, bus.aluOp}, 32'd0);
    chk("add_issue_ready", {31'd0, bus.inReady}, 32'd0);
    tick();
    bus.loadEn = 1'b0;
    chk("add_capture_ready", {31'd0, bus.inReady}, 32'd0);
    chk("add_capture_done", {31'd0, bus.done}, 32'd0);
    tick();
    chk("add_done", {31'd0, bus.done}, 32'd1);
    chk("add_zero_flag", {31'd0, bus.zeroFlag}, 32'd0);
    chk("add_retired", {16'd0, bus.retired}, 32'd1);
    chk_reg("add_r3", 3'd3, 32'd8);
    tick();
    chk("add_done_pulse", {31'd0, bus.done}, 32'd0);
    chk_reg("busy_load_r7", 3'd7, 32'd0);

    // sub r4,r1,r1 -> 0; xor r0,r1,r2 -> dropped
    run_op("sub", 3'b001, 3'd4, 3'd1, 3'd1);
    chk("sub_zero_flag", {31'd0, bus.zeroFlag}, 32'd1);
    chk_reg("sub_r4", 3'd4, 32'd0);
    run_op("xor", 3'b100, 3'd0, 3'd1, 3'd2);
    chk("xor_zero_flag", {31'd0, bus.zeroFlag}, 32'd0);
    chk("xor_retired", {16'd0, bus.retired}, 32'd3);
    chk_reg("xor_r0", 3'd0, 32'd0);

    // Back-to-back with inValid held: add r5,r1,r2 then add r6,r5,r5
    tick();
    bus.inValid = 1'b1;
    bus.inOp = 3'b000; bus.inRd = 3'd5; bus.inRs = 3'd1; bus.inRt = 3'd2;
    tick();
    bus.inRd = 3'd6; bus.inRs = 3'd5; bus.inRt = 3'd5;
    #1;
    chk("b2b_issue_ready", {31'd0, bus.inReady}, 32'd0);
    tick();
    chk("b2b_capture_ready", {31'd0, bus.inReady}, 32'd0);
    tick();
    chk("b2b_idle_ready", {31'd0, bus.inReady}, 32'd1);
    chk("b2b_first_done", {31'd0, bus.done}, 32'd1);
    tick();
    bus.inValid = 1'b0;
    chk("b2b_second_a", bus.aluA, 32'd8);
    tick();
    tick();
    chk("b2b_second_done", {31'd0, bus.done}, 32'd1);
    chk("b2b_retired", {16'd0, bus.retired}, 32'd5);
    chk_reg("b2b_r6", 3'd6, 32'd16);

    // Load and instruction in the same IDLE cycle; illegal opcode 3'b111 into r4
    load(3'd4, 32'd77);
    bus.loadEn   = 1'b1;
    bus.loadAddr = 3'd7;
    bus.loadData = 32'h55;
    bus.inValid  = 1'b1;
    bus.inOp = 3'b111; bus.inRd = 3'd4; bus.inRs = 3'd1; bus.inRt = 3'd2;
    #1;
    chk("ldv_ready", {31'd0, bus.inReady}, 32'd0);
    tick();
    bus.loadEn = 1'b0;
    #1;
    chk("ldv_ready_next", {31'd0, bus.inReady}, 32'd1);
    chk_reg("ldv_r7", 3'd7, 32'h55);
    tick();
    bus.inValid = 1'b0;
    chk("ill_flag", {31'd0, bus.illegalOp}, 32'd1);
    chk("ill_alu_op", {29'd0, bus.aluOp}, 32'd7);
    tick();
    tick();
    chk("ill_done", {31'd0, bus.done}, 32'd1);
    chk("ill_zero_flag", {31'd0, bus.zeroFlag}, 32'd1);
    chk("ill_retired", {16'd0, bus.retired}, 32'd6);
    chk_reg("ill_r4", 3'd4, 32'd0);
    run_op("and", 3'b010, 3'd1, 3'd1, 3'd2);
    chk("and_illegal_sticky", {31'd0, bus.illegalOp}, 32'd1);
    chk("and_zero_flag", {31'd0, bus.zeroFlag}, 32'd0);
    chk_reg("and_r1", 3'd1, 32'd1);

    // clear during ISSUE
    tick();
    bus.inValid = 1'b1;
    bus.inOp = 3'b000; bus.inRd = 3'd3; bus.inRs = 3'd1; bus.inRt = 3'd2;
    tick();
    bus.inValid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_ready", {31'd0, bus.inReady}, 32'd1);
    chk("clr_done", {31'd0, bus.done}, 32'd0);
    chk("clr_retired", {16'd0, bus.retired}, 32'd0);
    chk("clr_illegal", {31'd0, bus.illegalOp}, 32'd0);
    chk("clr_zero_flag", {31'd0, bus.zeroFlag}, 32'd1);
    chk("clr_alu_a", bus.aluA, 32'd0);
    tick();
    chk("clr_no_done", {31'd0, bus.done}, 32'd0);
    chk_reg("clr_r1", 3'd1, 32'd0);
    chk_reg("clr_r3", 3'd3, 32'd0);
    tick();
    chk("clr_still_retired", {16'd0, bus.retired}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
